// File: rtl/systolic_pkg.sv
// systolic_pkg: shared defaults and feeder state type for the systolic array edge feeders
package systolic_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int N_DEF = 4;
  typedef enum logic [2:0] {LOAD, WAIT, CLR, FEED, DRAIN, DONE} state_e;
endpackage

// File: rtl/systolic_west_feeder_if.sv
// systolic_west_feeder_if: row-load handshake, start request and array-edge stream of a feeder
interface systolic_west_feeder_if #(
  parameter int N = systolic_pkg::N_DEF,
  parameter int DATA_W = systolic_pkg::DATA_W_DEF
);
  logic load_valid;
  logic load_ready;
  logic [N*DATA_W-1:0] load_row;
  logic start;
  logic [N*DATA_W-1:0] feed_west;
  logic feed_active;
  logic acc_clr;
  logic done;
  modport master (
    output load_valid, load_row, start,
    input load_ready, feed_west, feed_active, acc_clr, done
  );
  modport slave (
    input load_valid, load_row, start,
    output load_ready, feed_west, feed_active, acc_clr, done
  );
endinterface

// File: rtl/systolic_west_feeder.sv
// systolic_west_feeder: buffers an NxN matrix row by row and streams it diagonally skewed into the array west edge
module systolic_west_feeder
  import systolic_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input logic clk,
  input logic rst,
  systolic_west_feeder_if.slave bus
);
  localparam int CW = $clog2(2 * N);
  state_e state_q, state_d;
  logic [CW-1:0] row_cnt_q, row_cnt_d, t_q, t_d;
  logic [N*DATA_W-1:0] mem_q [N];
  logic [N*DATA_W-1:0] feed_q, feed_d;
  logic feed_active_q, acc_clr_q, done_q;
  logic take;
  assign take = bus.load_valid && state_q == LOAD;
  assign bus.load_ready = state_q == LOAD;
  assign bus.feed_west = feed_q;
  assign bus.feed_active = feed_active_q;
  assign bus.acc_clr = acc_clr_q;
  assign bus.done = done_q;
  always_comb begin
    state_d = state_q;
    row_cnt_d = row_cnt_q;
    t_d = t_q;
    case (state_q)
      LOAD: if (take) begin
        state_d = row_cnt_q == CW'(N - 1) ? WAIT : LOAD;
        row_cnt_d = row_cnt_q == CW'(N - 1) ? '0 : row_cnt_q + 1'b1;
      end
      WAIT: state_d = bus.start ? CLR : WAIT;
      CLR: begin
        state_d = FEED;
        t_d = '0;
      end
      FEED: begin
        state_d = t_q == CW'(2 * N - 2) ? DRAIN : FEED;
        t_d = t_q == CW'(2 * N - 2) ? '0 : t_q + 1'b1;
      end
      DRAIN: begin
        state_d = t_q == CW'(N - 2) ? DONE : DRAIN;
        t_d = t_q == CW'(N - 2) ? '0 : t_q + 1'b1;
      end
      default: state_d = LOAD;
    endcase
  end
  // lane i carries element k of row i when t == i + k, giving the diagonal skew
  always_comb begin
    feed_d = '0;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++)
        if (state_d == FEED && t_d == CW'(i + k))
          feed_d[i*DATA_W +: DATA_W] = mem_q[i][k*DATA_W +: DATA_W];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      row_cnt_q <= '0;
      t_q <= '0;
      feed_q <= '0;
      feed_active_q <= 1'b0;
      acc_clr_q <= 1'b0;
      done_q <= 1'b0;
      for (int r = 0; r < N; r++) mem_q[r] <= '0;
    end else begin
      state_q <= state_d;
      row_cnt_q <= row_cnt_d;
      t_q <= t_d;
      feed_q <= feed_d;
      feed_active_q <= state_d == FEED || state_d == DRAIN;
      acc_clr_q <= state_d == CLR;
      done_q <= state_d == DONE;
      for (int r = 0; r < N; r++)
        if (take && row_cnt_q == CW'(r)) mem_q[r] <= bus.load_row;
    end
  end
endmodule

// File: tb/tb_systolic_west_feeder.sv
// tb_systolic_west_feeder: directed stimulus checked every cycle against a pass-timeline model plus literal tables
module tb_systolic_west_feeder;
  localparam int N = 4;
  localparam int DW = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_pass = 0;
  bit chk_on = 1'b0;
  bit lit_on = 1'b0;
  int act_cnt = 0;
  int ph = 0;
  int nrows = 0;
  int c = 0;
  logic [DW-1:0] a_m [N][N];
  int lit [12][4] = '{'{0,0,0,0}, '{1,0,0,0}, '{2,5,0,0}, '{3,6,9,0}, '{4,7,10,13},
                      '{0,8,11,14}, '{0,0,12,15}, '{0,0,0,16}, '{0,0,0,0}, '{0,0,0,0},
                      '{0,0,0,0}, '{0,0,0,0}};
  systolic_west_feeder_if #(.N(N), .DATA_W(DW)) bus ();
  systolic_west_feeder #(.N(N), .DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [N*DW-1:0] mk(input int e0, input int e1, input int e2, input int e3);
    return {DW'(e3), DW'(e2), DW'(e1), DW'(e0)};
  endfunction
  function automatic logic [N*DW-1:0] exp_feed();
    logic [N*DW-1:0] f = '0;
    int t = c - 1;
    if (ph == 2 && c >= 1 && c <= 2 * N - 1)
      for (int i = 0; i < N; i++)
        if (t >= i && t - i < N) f[i*DW +: DW] = a_m[i][t-i];
    return f;
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
  endtask
  // model: phase 0 loading, 1 waiting for start, 2 pass with c counting cycles from the clear cycle
  always @(posedge clk) begin
    if (rst) begin
      ph = 0;
      nrows = 0;
      c = 0;
    end else if (ph == 0) begin
      if (bus.load_valid) begin
        for (int k = 0; k < N; k++) a_m[nrows][k] = bus.load_row[k*DW +: DW];
        nrows++;
        if (nrows == N) begin
          ph = 1;
          nrows = 0;
        end
      end
    end else if (ph == 1) begin
      if (bus.start) begin
        ph = 2;
        c = 0;
      end
    end else if (c == 3 * N - 1) ph = 0;
    else c++;
  end
  always @(negedge clk) begin
    if (chk_on) begin
      chk("load_ready", 64'(bus.load_ready), 64'(ph == 0));
      chk("acc_clr", 64'(bus.acc_clr), 64'(ph == 2 && c == 0));
      chk("feed_active", 64'(bus.feed_active), 64'(ph == 2 && c >= 1 && c <= 3 * N - 2));
      chk("done", 64'(bus.done), 64'(ph == 2 && c == 3 * N - 1));
      chk("feed_west", 64'(bus.feed_west), 64'(exp_feed()));
      if (lit_on && ph == 2) begin
        chk("lit_feed", 64'(bus.feed_west), 64'(mk(lit[c][0], lit[c][1], lit[c][2], lit[c][3])));
        if (c == 0) act_cnt = 0;
        act_cnt += int'(bus.feed_active);
        if (c == 11) begin
          chk("lit_active_cycles", 64'(act_cnt), 64'd10);
          chk("lit_done", 64'(bus.done), 64'd1);
        end
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask
  task automatic send(input logic [N*DW-1:0] row, input int gap);
    bus.load_valid = 1'b1;
    bus.load_row = row;
    tick(1);
    bus.load_valid = 1'b0;
    bus.load_row = '1;
    tick(gap);
  endtask
  task automatic pulse_start();
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
  endtask
  initial begin
    bus.load_valid = 1'b0;
    bus.load_row = '0;
    bus.start = 1'b0;
    tick(2);
    rst = 1'b0;
    chk_on = 1'b1;
    lit_on = 1'b1;
    for (int r = 0; r < N; r++) send(mk(4*r+1, 4*r+2, 4*r+3, 4*r+4), 0);
    tick(1);
    pulse_start();
    tick(14);
    lit_on = 1'b0;
    send(mk(21, 22, 23, 24), 1);
    pulse_start();
    send(mk(31, 32, 33, 34), 2);
    send(mk(41, 42, 43, 44), 0);
    send(mk(51, 52, 53, 54), 1);
    bus.load_valid = 1'b1;
    bus.load_row = mk(16'hdead, 16'hbeef, 16'hdead, 16'hbeef);
    tick(2);
    pulse_start();
    bus.load_valid = 1'b0;
    tick(14);
    for (int r = 0; r < N; r++) send(mk(100+r, 200+r, 300+r, 400+r), 0);
    pulse_start();
    tick(4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(2);
    for (int r = 0; r < N; r++) send(mk(r+7, r+17, r+27, r+37), r & 1);
    pulse_start();
    tick(15);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
